// File: rtl/dm_pkg.sv
// Shared encodings and byte-lane helpers for the M-stage data memory.
package dm_pkg;

  localparam int DM_DEPTH_WORDS = 4096;

  localparam logic [1:0] ST_SW  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SB  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  function automatic logic [3:0] be_f(
    input logic [1:0] st,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (st)
      ST_SW: if (off == 2'd0) be = 4'b1111;
      ST_SH: begin
        if (off == 2'd0) be = 4'b0011;
        if (off == 2'd2) be = 4'b1100;
      end
      ST_SB: be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic st_mis_f(
    input logic [1:0] st,
    input logic [1:0] off
  );
    return (st == ST_SW && off != 2'd0) ||
           (st == ST_SH && off[0]);
  endfunction

  function automatic logic ld_mis_f(
    input logic [2:0] lt,
    input logic [1:0] off
  );
    logic mis;
    case (lt)
      LD_LBU, LD_LB: mis = 1'b0;
      LD_LHU, LD_LH: mis = off[0];
      default:       mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension ahead of the W register.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (load_type_i)
      LD_LBU:  data_o = {24'b0, b};
      LD_LB:   data_o = {{24{b[7]}}, b};
      LD_LHU:  data_o = {16'b0, h};
      LD_LH:   data_o = {{16{h[15]}}, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_byte_ctrl.sv
// M-stage data memory: byte/half/word stores, extended loads into W.
// Optional store/misalign trace when DM_TRACE_EN is defined.
module dm_byte_ctrl
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        mem_write,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_m,
  output logic [31:0] rdata_w,
  output logic        addr_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   rel;
  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   wrep;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic [31:0]   ld_ext;
  logic [3:0]    be;
  logic          st_mis;
  logic          ld_mis;
  logic          unused_ok;

  assign rel     = addr - BASE_ADDR;
  assign idx     = rel[IW+1:2];
  assign off     = addr[1:0];
  assign rd_word = mem_q[idx];

  // A cycle without mem_write is treated as a potential load.
  assign st_mis = mem_write && st_mis_f(store_type, off);
  assign ld_mis = !mem_write && ld_mis_f(load_type, off);
  assign be     = mem_write ? be_f(store_type, off) : 4'b0000;

  always_comb begin
    case (store_type)
      ST_SB:   wrep = {4{wdata[7:0]}};
      ST_SH:   wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
    for (int l = 0; l < 4; l++) begin
      merged[8*l +: 8] = be[l] ? wrep[8*l +: 8] : rd_word[8*l +: 8];
    end
  end

  dm_load_ext u_ext (
    .word_i      (rd_word),
    .off_i       (off),
    .load_type_i (load_type),
    .data_o      (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (|be) mem_q[idx] <= merged;
      if (!stall) rdata_q <= ld_mis ? 32'h0 : ld_ext;
      if (st_mis || (ld_mis && !stall)) err_q <= 1'b1;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (|be)
        $display("@%h: *%h <= %h", pc_m, {addr[31:2], 2'b00}, merged);
      if (st_mis || (ld_mis && !stall))
        $display("@%h: misaligned %h", pc_m, addr);
    end
  end
`endif

  assign unused_ok = ^{rel[31:IW+2], rel[1:0], pc_m};
  assign rdata_w   = rdata_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_dm_byte_ctrl.sv
// Scoreboard bench for dm_byte_ctrl: directed ops, queued expectations.
module tb_dm_byte_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  store_type = ST_SW;
  logic [2:0]  load_type = LD_LW;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pc_m = '0;
  logic [31:0] rdata_w;
  logic        addr_err;

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       nm;
  } exp_t;

  exp_t q[$];
  bit   chk_en = 1'b0;
  bit   chk_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dm_byte_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .mem_write  (mem_write),
    .store_type (store_type),
    .load_type  (load_type),
    .addr       (addr),
    .wdata      (wdata),
    .pc_m       (pc_m),
    .rdata_w    (rdata_w),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) chk_vld <= chk_en;

  always @(negedge clk) begin
    if (chk_vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty got %h", rdata_w);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (rdata_w !== x.d) begin
          errors++;
          $display("FAIL %s rdata got %h exp %h", x.nm, rdata_w, x.d);
        end
        checks++;
        if (addr_err !== x.e) begin
          errors++;
          $display("FAIL %s addr_err got %b exp %b", x.nm, addr_err, x.e);
        end
      end
    end
  end

  task automatic op(
    input logic        r,
    input logic        st,
    input logic        mw,
    input logic [1:0]  stt,
    input logic [2:0]  ldt,
    input logic [31:0] a,
    input logic [31:0] wd,
    input bit          chk,
    input logic [31:0] ed,
    input logic        ee,
    input string       nm
  );
    @(negedge clk);
    reset      = r;
    stall      = st;
    mem_write  = mw;
    store_type = stt;
    load_type  = ldt;
    addr       = a;
    wdata      = wd;
    pc_m       = pc_m + 32'd4;
    chk_en     = chk;
    if (chk) q.push_back('{ed, ee, nm});
  endtask

  task automatic st_op(input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] wd);
    op(0, 0, 1, t, LD_LW, a, wd, 0, 0, 0, "");
  endtask

  task automatic ld_op(input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] ed, input logic ee,
                       input string nm);
    op(0, 0, 0, ST_SW, t, a, 0, 1, ed, ee, nm);
  endtask

  initial begin
    op(1, 0, 0, ST_SW, LD_LW, 0, 0, 1, 32'h0, 0, "reset");
    ld_op(LD_LW, 32'h0, 32'h0, 0, "lw0_after_reset");
    st_op(ST_SW, 32'h10, 32'h1234_5678);
    ld_op(LD_LW, 32'h10, 32'h1234_5678, 0, "sw_lw");
    st_op(ST_SB, 32'h11, 32'h0000_00AB);
    ld_op(LD_LW, 32'h10, 32'h1234_AB78, 0, "sb_merge");
    ld_op(LD_LB, 32'h11, 32'hFFFF_FFAB, 0, "lb_sext");
    ld_op(LD_LBU, 32'h11, 32'h0000_00AB, 0, "lbu_zext");
    st_op(ST_SH, 32'h12, 32'h0000_8001);
    ld_op(LD_LH, 32'h12, 32'hFFFF_8001, 0, "lh_sext");
    ld_op(LD_LHU, 32'h12, 32'h0000_8001, 0, "lhu_zext");
    ld_op(LD_LW, 32'h10, 32'h8001_AB78, 0, "sh_merge");
    ld_op(LD_LB, 32'h13, 32'hFFFF_FF80, 0, "lb_lane3");
    ld_op(LD_LHU, 32'h10, 32'h0000_AB78, 0, "lhu_lo");
    ld_op(3'd6, 32'h10, 32'h8001_AB78, 0, "ldt_other_lw");
    ld_op(LD_LW, 32'h4010, 32'h8001_AB78, 0, "idx_wrap");
    st_op(ST_RSV, 32'h10, 32'hFFFF_FFFF);
    ld_op(LD_LW, 32'h10, 32'h8001_AB78, 0, "reserved_nowr");
    st_op(ST_SW, 32'h20, 32'hCAFE_F00D);
    st_op(ST_SW, 32'h21, 32'hDEAD_BEEF);
    ld_op(LD_LW, 32'h20, 32'hCAFE_F00D, 1, "sw_misaligned");
    st_op(ST_SH, 32'h23, 32'h0000_1111);
    ld_op(LD_LW, 32'h20, 32'hCAFE_F00D, 1, "sh_misaligned");
    ld_op(LD_LW, 32'h12, 32'h0, 1, "lw_mis_zero");
    ld_op(LD_LW, 32'h10, 32'h8001_AB78, 1, "err_sticky");
    ld_op(LD_LH, 32'h11, 32'h0, 1, "lh_mis_zero");
    ld_op(LD_LW, 32'h10, 32'h8001_AB78, 1, "pre_stall");
    op(0, 1, 1, ST_SB, LD_LW, 32'h0, 32'h55, 1, 32'h8001_AB78, 1,
       "stall_hold");
    ld_op(LD_LW, 32'h0, 32'h0000_0055, 1, "stall_write");
    op(1, 0, 1, ST_SW, LD_LW, 32'h10, 32'h777, 1, 32'h0, 0, "mid_reset");
    ld_op(LD_LW, 32'h10, 32'h0, 0, "post_reset_lw");
    ld_op(LD_LW, 32'h20, 32'h0, 0, "post_reset_lw20");
    op(0, 0, 0, ST_SW, LD_LW, 32'h0, 0, 0, 0, 0, "");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_byte_ctrl.md
# dm_byte_ctrl

M-stage data memory with byte/halfword/word store and W-stage load extension. Sits directly downstream of the M-level ALU result. It uses the full address to index the word array and the low two address bits to pick byte lanes. The read result is extended and handed to the W stage through an internal M/W data register.

## Interface
Parameters:
- `DEPTH_WORDS`, default 4096: number of 32-bit words; index = `addr[13:2]` (width = log2(DEPTH_WORDS)).
- `BASE_ADDR`, default 32'h0000_0000: subtracted from `addr` before indexing.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: holds the W output register (the memory write still occurs).
- `mem_write` input 1: store request for the current M instruction.
- `store_type` input 2: 0 = SW, 1 = SH, 2 = SB, 3 = reserved (treated as no write).
- `load_type` input 3: 0 = LW, 1 = LBU, 2 = LB, 3 = LHU, 4 = LH, others = LW.
- `addr` input 32: M-level ALU result (effective address).
- `wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `pc_m` input 32: PC of the M instruction, used only for the trace.
- `rdata_w` output 32: extended load data for W.
- `addr_err` output 1: sticky misalignment flag.

## Operation
- Word index `idx = (addr - BASE_ADDR) >> 2`, truncated to the index width. Out-of-range upper bits are ignored (wrap-around).
- Byte offset `off = addr[1:0]`.
- Store byte enables:
  - SW: 4'b1111, only when `off == 0`.
  - SH: 4'b0011 when `off == 0`, 4'b1100 when `off == 2`.
  - SB: 4'b0001 shifted left by `off`.
  - `wdata` is replicated across lanes (byte x4, half x2); enabled lanes are written, other lanes keep their value.
- Misaligned access:
  - Applies to SW/LW with `off != 0`, and to SH/LH/LHU with `off[0] == 1`.
  - No write occurs; `addr_err` is set to 1 and stays 1 until `reset`.
  - For a misaligned load, `rdata_w` captures 0.
- Load: the word at `idx` is read combinationally in M, the lane is selected by `off`, then extended:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- The extended value is registered into `rdata_w` at the clock edge unless `stall` is high.
- Reset:
  - All memory words are cleared to 0.
  - `rdata_w` = 0, `addr_err` = 0.
  - Any write in the reset cycle is discarded.

## Timing
- Store: the array updates at the rising edge ending the M cycle of the store.
- Load latency: 1 cycle. Data is valid on `rdata_w` during the instruction's W cycle.
- Load to the same word in the cycle immediately after a store: returns the newly written data (the write precedes the next read).
- `stall` high: `rdata_w` holds; the array write is unaffected. Upstream must deassert `mem_write` during stall bubbles.
- `reset` mid-stream: takes effect at that edge; the next cycle behaves as after power-up.

## Configuration
- `DM_TRACE_EN` defined:
  - Each committed store prints `@<pc_m>: *<word-aligned addr> <= <merged 32-bit word>` via `$display` at the write edge.
  - Misaligned attempts print `@<pc_m>: misaligned <addr>`.
- `DM_TRACE_EN` undefined: no display logic is compiled; behaviour is otherwise identical.

## Structure
- Shared package `dm_pkg`:
  - `store_type` and `load_type` encodings as localparams/enums.
  - Default `DEPTH_WORDS`.
  - The byte-enable function.
- One sub-module, `dm_load_ext`: combinational lane select and extension. Inputs: 32-bit word, `off`, `load_type`. Output: 32 bits. Instantiated once before the W register.

## Test plan
- Reset, then LW at 0x0 → `rdata_w` = 0 one cycle later; `addr_err` = 0.
- SW 0x1234_5678 to 0x10, then LW 0x10 next cycle → `rdata_w` = 0x1234_5678.
- SB 0x000000AB to 0x11 over that word, then LW 0x10 → 0x1234_AB78. Then LB 0x11 → 0xFFFF_FFAB; LBU 0x11 → 0x0000_00AB.
- SH 0x0000_8001 to 0x12, then LH 0x12 → 0xFFFF_8001; LHU 0x12 → 0x0000_8001; LW 0x10 → 0x8001_AB78.
- SW to 0x21 → memory at word 0x20 unchanged and `addr_err` = 1. `addr_err` stays 1 through later aligned accesses and clears only on `reset`.
- LW 0x10 with `stall` asserted the next cycle → `rdata_w` holds its value. Assert `reset` mid-sequence → `rdata_w` = 0 and LW 0x10 returns 0.
